// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the FP divider arbiter.
// FP_DIV_ARBITER_DIV0_FLAG_EN adds a divide-by-zero bit to the tag record.
package fp_arb_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_LATENCY = 6;
    // Wide enough for the largest legal requester count (8).
    localparam int unsigned TAG_IDX_W   = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
        logic                 div0;
`endif
    } tag_t;

    function automatic logic is_zero_divisor(input logic [FP_W-1:0] b);
        return (b[FP_W-2:0] == '0);
    endfunction

endpackage

// File: rtl/fp_div_arbiter_if.sv
// Requester-side bus of the FP divider arbiter.
// FP_DIV_ARBITER_DIV0_FLAG_EN adds the rsp_div0 response bit.
interface fp_div_arbiter_if
    import fp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
);

    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*FP_W-1:0] req_a;
    logic [NUM_REQ*FP_W-1:0] req_b;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [FP_W-1:0]         rsp_data;
`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
    logic                    rsp_div0;

    modport master (output req, req_a, req_b,
                    input  grant, rsp_valid, rsp_data, rsp_div0);
    modport slave  (input  req, req_a, req_b,
                    output grant, rsp_valid, rsp_data, rsp_div0);
`else
    modport master (output req, req_a, req_b,
                    input  grant, rsp_valid, rsp_data);
    modport slave  (input  req, req_a, req_b,
                    output grant, rsp_valid, rsp_data);
`endif

endinterface

// File: rtl/rr_select.sv
// Round-robin selector: one-hot grant to the first asserted req after ptr.
module rr_select #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        // Offsets 1..NUM_REQ visit ptr+1 first and ptr itself last.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (32'(ptr) + k) % NUM_REQ)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one pipelined FP divider; results routed by tag.
// FP_DIV_ARBITER_DIV0_FLAG_EN adds rsp_div0 carried through the tag pipe.
module fp_div_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic                           clk,
    input  logic                           program_reset,
    fp_div_arbiter_if.slave                bus,
    output logic [FP_W-1:0]                divider_data_a,
    output logic [FP_W-1:0]                divider_data_b,
    input  logic [FP_W-1:0]                divider_out,
    output logic                           busy,
    output logic [$clog2(LATENCY+1)-1:0]   in_flight
);

    logic [TAG_IDX_W-1:0] ptr;
    logic [TAG_IDX_W-1:0] gnt_idx;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   ret_mask;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [FP_W-1:0]      sel_a;
    logic [FP_W-1:0]      sel_b;
    logic                 issue;
    logic                 ret;
    tag_t                 new_tag;
    tag_t                 tail;
    tag_t                 pipe [LATENCY];
`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
    logic                 rsp_div0_q;
`endif

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (TAG_IDX_W)
    ) u_rr_select (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        gnt_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = TAG_IDX_W'(i);
                sel_a   = bus.req_a[i*FP_W +: FP_W];
                sel_b   = bus.req_b[i*FP_W +: FP_W];
            end
        end
    end

    assign issue = |grant;
    assign tail  = pipe[LATENCY-1];
    assign ret   = tail.valid;

    always_comb begin
        new_tag       = '0;
        new_tag.valid = issue;
        new_tag.idx   = gnt_idx;
`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
        new_tag.div0  = is_zero_divisor(sel_b);
`endif
    end

    always_comb begin
        ret_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ret_mask[i] = tail.valid && (tail.idx == TAG_IDX_W'(i));
        end
    end

    // The last tag stage is registered into rsp_valid, which lines the strobe
    // up with the divider result one cycle after the operands leave the pipe.
    always_ff @(posedge clk or posedge program_reset) begin
        if (program_reset) begin
            ptr            <= TAG_IDX_W'(NUM_REQ - 1);
            divider_data_a <= '0;
            divider_data_b <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                pipe[s] <= '0;
            end
            in_flight      <= '0;
            rsp_valid_q    <= '0;
`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
            rsp_div0_q     <= 1'b0;
`endif
        end else begin
            if (issue) begin
                ptr            <= gnt_idx;
                divider_data_a <= sel_a;
                divider_data_b <= sel_b;
            end
            pipe[0] <= new_tag;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                pipe[s] <= pipe[s-1];
            end
            rsp_valid_q <= ret_mask;
`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
            rsp_div0_q  <= tail.valid && tail.div0;
`endif
            case ({issue, ret})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign busy          = (in_flight != '0);
    assign bus.grant     = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = divider_out;
`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
    assign bus.rsp_div0  = rsp_div0_q;
`endif

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed-vector bench for fp_div_arbiter with a table-driven divider stand-in.
// FP_DIV_ARBITER_DIV0_FLAG_EN enables the rsp_div0 vectors.
module tb_fp_div_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = 6;

    localparam logic [31:0] F0_5 = 32'h3F000000;
    localparam logic [31:0] F1   = 32'h3F800000;
    localparam logic [31:0] F2   = 32'h40000000;
    localparam logic [31:0] F3   = 32'h40400000;
    localparam logic [31:0] F4   = 32'h40800000;
    localparam logic [31:0] F5   = 32'h40A00000;
    localparam logic [31:0] F6   = 32'h40C00000;
    localparam logic [31:0] F8   = 32'h41000000;
    localparam logic [31:0] F10  = 32'h41200000;
    localparam logic [31:0] NEG0 = 32'h80000000;

    logic        clk = 1'b0;
    logic        program_reset;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_out;
    logic        busy;
    logic [2:0]  in_flight;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] exp_d [5] = '{F3, F0_5, F4, F5, F3};
    logic [3:0]  exp_t4 [3] = '{4'b0001, 4'b0010, 4'b0100};

    fp_div_arbiter_if #(.NUM_REQ(NR)) bus ();

    fp_div_arbiter #(
        .NUM_REQ (NR),
        .LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .program_reset  (program_reset),
        .bus            (bus),
        .divider_data_a (div_a),
        .divider_data_b (div_b),
        .divider_out    (div_out),
        .busy           (busy),
        .in_flight      (in_flight)
    );

    always #5 clk = ~clk;

    // Divider stand-in: LAT-cycle delay of the registered operands, then a lookup.
    logic [63:0] dpipe [LAT];
    always @(posedge clk) begin
        dpipe[0] <= {div_a, div_b};
        for (int i = 1; i < int'(LAT); i++) dpipe[i] <= dpipe[i-1];
    end

    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        if (a == F6  && b == F2) return F3;
        if (a == F1  && b == F2) return F0_5;
        if (a == F8  && b == F2) return F4;
        if (a == F10 && b == F2) return F5;
        if (a == F1  && b == F1) return F1;
        return 32'hDEADBEEF;
    endfunction

    assign div_out = quot(dpipe[LAT-1][63:32], dpipe[LAT-1][31:0]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int unsigned r, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[r*32 +: 32] = a;
        bus.req_b[r*32 +: 32] = b;
    endtask

    task automatic apply_reset();
        program_reset = 1'b1;
        tick();
        program_reset = 1'b0;
    endtask

`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
    task automatic div0_case(input logic [31:0] b, input logic exp);
        int k;
        set_op(1, F1, b);
        bus.req = 4'b0010;
        #1;
        tick();
        bus.req = '0;
        k = 1;
        while (bus.rsp_valid == '0 && k < 20) begin
            tick();
            k++;
        end
        chk("div0_latency", 32'(k), 32'd7);
        chk("div0_flag", 32'(bus.rsp_div0), 32'(exp));
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int unsigned pulses;
        logic [2:0]  maxf;
        logic [2:0]  prev;
        logic        mono;

        program_reset = 1'b1;
        bus.req       = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_in_flight", 32'(in_flight),     32'd0);
        chk("rst_data_a",    div_a,              32'd0);
        chk("rst_data_b",    div_b,              32'd0);
        bus.req = 4'b1111;
        #1;
        chk("rst_priority",  32'(bus.grant),     32'b0001);
        bus.req = '0;
        tick();
        tick();
        program_reset = 1'b0;

        // Single operation: 6.0 / 2.0
        tick();
        set_op(0, F6, F2);
        bus.req = 4'b0001;
        #1;
        chk("t1_grant", 32'(bus.grant), 32'b0001);
        tick();
        bus.req = '0;
        chk("t1_data_a",    div_a,           F6);
        chk("t1_data_b",    div_b,           F2);
        chk("t1_busy",      32'(busy),       32'd1);
        chk("t1_in_flight", 32'(in_flight),  32'd1);
        k = 1;
        while (bus.rsp_valid == '0 && k < 20) begin
            tick();
            k++;
        end
        chk("t1_latency",   32'(k),             32'd7);
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("t1_rsp_data",  bus.rsp_data,       F3);
        chk("t1_hold_a",    div_a,              F6);
        chk("t1_idle",      32'(busy),          32'd0);

        // All four requesting: back-to-back grants and in-order returns
        apply_reset();
        set_op(0, F6, F2);
        set_op(1, F1, F2);
        set_op(2, F8, F2);
        set_op(3, F10, F2);
        bus.req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t2_grant", 32'(bus.grant), 32'(exp_g[c]));
            tick();
        end
        bus.req = '0;
        chk("t2_in_flight", 32'(in_flight), 32'd5);
        k = 5;
        while (bus.rsp_valid == '0 && k < 20) begin
            tick();
            k++;
        end
        chk("t2_latency", 32'(k), 32'd7);
        for (int c = 0; c < 5; c++) begin
            chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'(exp_g[c]));
            chk("t2_rsp_data",  bus.rsp_data,       exp_d[c]);
            tick();
        end

        // Wrap-around: after 2, requester 3 idle so 0 wins, then 2 again
        bus.req = 4'b0100;
        #1;
        chk("t3_first2", 32'(bus.grant), 32'b0100);
        tick();
        bus.req = 4'b0101;
        #1;
        chk("t3_wrap0", 32'(bus.grant), 32'b0001);
        tick();
        #1;
        chk("t3_then2", 32'(bus.grant), 32'b0100);
        tick();
        bus.req = '0;
        chk("t3_data_a", div_a, F8);
        repeat (8) tick();
        chk("t3_drained", 32'(in_flight), 32'd0);

        // Reset with three operations in flight
        bus.req = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_grant", 32'(bus.grant), 32'(exp_t4[c]));
            tick();
        end
        bus.req = '0;
        chk("t4_in_flight", 32'(in_flight), 32'd3);
        program_reset = 1'b1;
        #1;
        chk("t4_rst_in_flight", 32'(in_flight), 32'd0);
        chk("t4_rst_busy",      32'(busy),      32'd0);
        tick();
        program_reset = 1'b0;
        bus.req = 4'b1111;
        #1;
        chk("t4_next_grant", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        pulses = 0;
        repeat (12) begin
            tick();
            if (bus.rsp_valid != '0) pulses++;
        end
        chk("t4_no_rsp",     pulses,          32'd0);
        chk("t4_in_flight0", 32'(in_flight),  32'd0);

        // Continuous issue: saturation at LATENCY, then drain
        set_op(0, F6, F2);
        bus.req = 4'b0001;
        maxf    = '0;
        pulses  = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (in_flight > maxf) maxf = in_flight;
            if (bus.rsp_valid[0]) pulses++;
        end
        bus.req = '0;
        chk("t5_saturated", 32'(in_flight), 32'd6);
        chk("t5_max",       32'(maxf),      32'd6);
        k    = 0;
        mono = 1'b1;
        prev = in_flight;
        while (in_flight != '0 && k < 20) begin
            tick();
            k++;
            if (in_flight != prev - 3'd1) mono = 1'b0;
            prev = in_flight;
            if (bus.rsp_valid[0]) pulses++;
        end
        chk("t5_drain_cycles", 32'(k),    32'd6);
        chk("t5_drain_steps",  32'(mono), 32'd1);
        chk("t5_rsp_count",    pulses,    32'd20);

`ifdef FP_DIV_ARBITER_DIV0_FLAG_EN
        div0_case(NEG0, 1'b1);
        div0_case(F1,   1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fp_div_arbiter.md
FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one pipelined FP divider; legal range 2..8.
REQ-002 Parameter LATENCY, default 6: divider clock latency, from operands registered to result valid; legal range 1..16.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port program_reset  input  1: reset, asynchronous and active-high.
REQ-005 Port req  input  NUM_REQ: per-requester request; held high with operands stable until granted.
REQ-006 Port req_a  input  NUM_REQ*32: IEEE-754 single dividends, requester i in bits [32i+31:32i].
REQ-007 Port req_b  input  NUM_REQ*32: IEEE-754 single divisors, same packing.
REQ-008 Port grant  output  NUM_REQ: one-hot or zero; combinational from req and the round-robin pointer.
REQ-009 Port divider_data_a  output  32: registered dividend to the divider IP.
REQ-010 Port divider_data_b  output  32: registered divisor to the divider IP.
REQ-011 Port divider_out  input  32: divider IP result.
REQ-012 Port rsp_valid  output  NUM_REQ: one-hot or zero; one-cycle result strobe to the owning requester.
REQ-013 Port rsp_data  output  32: divider_out, broadcast to all requesters.
REQ-014 Port busy  output  1: high while any operation is in flight.
REQ-015 Port in_flight  output  clog2(LATENCY+1): count of issued operations not yet returned.

Function
REQ-016 grant SHALL select, among asserted req bits, the first index after the last granted index, wrapping NUM_REQ-1 to 0; at most one grant per cycle.
REQ-017 On the edge where grant[i] is high, divider_data_a/b SHALL load requester i operands and the round-robin pointer SHALL become i.
REQ-018 With no grant, divider_data_a/b SHALL hold their values.
REQ-019 A tag shift register of LATENCY stages (valid bit plus requester index) SHALL record each issue and advance every cycle.
REQ-020 rsp_valid[i] SHALL be high exactly in the cycle LATENCY+1 cycles after the cycle grant[i] was high; rsp_data is valid in that same cycle.
REQ-021 Issues SHALL be fully pipelined: back-to-back grants in consecutive cycles are legal and return results in consecutive cycles, in order.
REQ-022 in_flight SHALL increment on issue and decrement on return; simultaneous issue and return SHALL leave it unchanged. in_flight never exceeds LATENCY.
REQ-023 busy SHALL equal (in_flight != 0).
REQ-024 A requester with a result in flight may issue again; every result SHALL be routed by its tag.
REQ-025 A request withdrawn before grant SHALL be ignored without error; a grant is never issued to a deasserted req bit.

Reset
REQ-026 program_reset SHALL immediately clear grant qualification state, the tag pipe, in_flight, busy, rsp_valid, divider_data_a/b (to 0), and set the pointer to NUM_REQ-1 so requester 0 has priority first.
REQ-027 Reset mid-operation SHALL discard all in-flight results; no rsp_valid SHALL pulse for operations issued before reset.

Configuration
REQ-028 Macro FP_DIV_ARBITER_DIV0_FLAG_EN defined: output rsp_div0 (1 bit) SHALL be added, carried in the tag, and assert with rsp_valid when the issued divisor had exponent and mantissa both zero.
REQ-029 Macro undefined: rsp_div0 and its tag bit SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package fp_arb_pkg SHALL hold the FP word width (32), default NUM_REQ and LATENCY, and the tag record (valid, index, optional div0).
REQ-031 The round-robin selector SHALL be the sub-module rr_select (req vector and pointer in, one-hot grant out); the divider IP stays outside this block.

Verification
REQ-032 Reset, then req=4'b0001, a=6.0, b=2.0 -> grant[0] same cycle; rsp_valid[0] 7 cycles later with rsp_data=3.0 (0x40400000); busy high in between.
REQ-033 req=4'b1111 held, all distinct operands -> grants 0,1,2,3,0 in consecutive cycles; rsp_valid 1,2,4,8 one-hot in consecutive cycles, matching results.
REQ-034 Grant to requester 2, then req=4'b0101 -> next grant to 0 (wrap after 2 skips 3), then 2.
REQ-035 Issue 3 ops, assert program_reset at cycle 3 for one cycle -> no rsp_valid for those ops, in_flight=0, next grant to requester 0.
REQ-036 Issue on every cycle for 20 cycles -> in_flight saturates at 6 and stays there; drains 6->0 after req drops.
REQ-037 With FP_DIV_ARBITER_DIV0_FLAG_EN, b=0x80000000 -> rsp_div0=1 with rsp_valid; b=1.0 -> rsp_div0=0.
